// File: rtl/g2_lane_pkg.sv
// Shared definitions for the lane-select path: default lane count, collector
// FSM states and the index-to-one-hot width helper.
package g2_lane_pkg;

    localparam int LANES_DEFAULT = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } lane_collect_state_e;

    // Width of a one-hot vector addressed by an idx_w-bit index.
    function automatic int onehot_width(input int idx_w);
        return 1 << idx_w;
    endfunction

endpackage

// File: rtl/lane_idx_decode.sv
// Combinational lane index to one-hot decoder used by the mask collector.
module lane_idx_decode
    import g2_lane_pkg::*;
#(
    parameter int W_LANES = LANES_DEFAULT,
    parameter int W_IDX   = $clog2(W_LANES)
) (
    input  logic [W_IDX-1:0]   idx_i,
    output logic [W_LANES-1:0] onehot_o
);

    assign onehot_o = W_LANES'(1) << idx_i;

endmodule

// File: rtl/lane_mask_collector.sv
// Rebuilds a warp's active-lane mask from a stream of lane-index beats.
// Optional macro LANE_COLLECT_ERR_CHECK_EN enables duplicate/tag-mismatch checks.
module lane_mask_collector
    import g2_lane_pkg::*;
#(
    parameter int W_LANES = LANES_DEFAULT,
    parameter int W_IDX   = $clog2(W_LANES),
    parameter int W_TAG   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_IDX-1:0]   in_idx,
    input  logic [W_TAG-1:0]   in_tag,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_LANES-1:0] out_mask,
    output logic [W_IDX:0]     out_count,
    output logic [W_TAG-1:0]   out_tag,
    output logic               out_err
);

    localparam int W_ONEHOT = onehot_width(W_IDX);
    localparam int W_CNT    = W_IDX + 1;

    lane_collect_state_e  state_q;
    logic [W_LANES-1:0]   mask_q, mask_d;
    logic [W_ONEHOT-1:0]  idx_onehot;
    logic [W_CNT-1:0]     count_q, count_d;
    logic [W_TAG-1:0]     tag_q, tag_d;
    logic                 first_q;
    logic                 beat_fire;

    lane_idx_decode #(
        .W_LANES (W_LANES),
        .W_IDX   (W_IDX)
    ) u_idx_decode (
        .idx_i    (in_idx),
        .onehot_o (idx_onehot)
    );

    // Handshake signals come straight off the state register, never off out_ready.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == EMIT);
    assign beat_fire = in_valid && in_ready;

`ifdef LANE_COLLECT_ERR_CHECK_EN
    logic err_q, err_d;
    logic dup_hit;

    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        mask_d  = mask_q | idx_onehot;
        tag_d   = first_q ? in_tag : tag_q;
        dup_hit = |(mask_q & idx_onehot);
        count_d = count_q + W_CNT'(!dup_hit);
        err_d   = err_q | dup_hit | (!first_q && (in_tag != tag_q));
    end

    assign out_err = err_q;
`else
    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(W_LANES);

    always_comb begin
        mask_d  = mask_q | idx_onehot;
        tag_d   = first_q ? in_tag : tag_q;
        // Without checking, every beat counts; saturate instead of wrapping.
        count_d = (count_q == CNT_MAX) ? count_q : count_q + W_CNT'(1);
    end

    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update from the same pre-edge values.
        if (rst) begin
            state_q <= COLLECT;
            mask_q  <= '0;
            count_q <= '0;
            tag_q   <= '0;
            first_q <= 1'b1;
`ifdef LANE_COLLECT_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (beat_fire) begin
                        mask_q  <= mask_d;
                        count_q <= count_d;
                        tag_q   <= tag_d;
                        first_q <= 1'b0;
`ifdef LANE_COLLECT_ERR_CHECK_EN
                        err_q   <= err_d;
`endif
                        if (in_last) begin
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        mask_q  <= '0;
                        count_q <= '0;
                        first_q <= 1'b1;
`ifdef LANE_COLLECT_ERR_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign out_mask  = mask_q;
    assign out_count = count_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_lane_mask_collector.sv
// Self-checking bench for lane_mask_collector: directed groups plus random groups
// compared against a queue-based group model.
module tb_lane_mask_collector;

    localparam int LANES = 32;
    localparam int IDXW  = 5;
    localparam int TAGW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [IDXW-1:0] in_idx;
    logic [TAGW-1:0] in_tag;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [LANES-1:0] out_mask;
    logic [IDXW:0]   out_count;
    logic [TAGW-1:0] out_tag;
    logic            out_err;

    int vectors     = 0;
    int miscompares = 0;

    // Beats of the group currently being sent.
    int grp_idx[$];
    int grp_tag[$];

    always #5 clk = ~clk;

    lane_mask_collector #(
        .W_LANES (LANES),
        .W_TAG   (TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_tag    (in_tag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected results derived from the group's beat list.
    function automatic logic [LANES-1:0] model_mask();
        logic [LANES-1:0] m = '0;
        foreach (grp_idx[i]) m[grp_idx[i]] = 1'b1;
        return m;
    endfunction

    function automatic int model_count();
`ifdef LANE_COLLECT_ERR_CHECK_EN
        return $countones(model_mask());
`else
        return (grp_idx.size() > LANES) ? LANES : grp_idx.size();
`endif
    endfunction

    function automatic bit model_err();
`ifdef LANE_COLLECT_ERR_CHECK_EN
        for (int i = 1; i < grp_idx.size(); i++) begin
            if (grp_tag[i] != grp_tag[0]) return 1'b1;
            for (int j = 0; j < i; j++)
                if (grp_idx[i] == grp_idx[j]) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic send_beat(input int idx, input int tag, input bit last);
        in_valid = 1'b1;
        in_idx   = IDXW'(idx);
        in_tag   = TAGW'(tag);
        in_last  = last;
        check("beat_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        grp_idx.push_back(idx);
        grp_tag.push_back(tag);
        if (!last) check("collect_out_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic expect_group(input string name, input int stall);
        logic [LANES-1:0] m = model_mask();
        int c = model_count();
        bit e = model_err();
        int t = grp_tag[0];
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        for (int s = 0; s <= stall; s++) begin
            check({name, "_mask"},     64'(out_mask),  64'(m));
            check({name, "_count"},    64'(out_count), 64'(c));
            check({name, "_tag"},      64'(out_tag),   64'(t));
            check({name, "_err"},      64'(out_err),   64'(e));
            check({name, "_in_ready"}, 64'(in_ready),  64'(0));
            if (s < stall) begin
                // Upstream presenting a beat during EMIT must be ignored.
                in_valid = 1'b1;
                in_idx   = IDXW'($urandom);
                in_tag   = TAGW'($urandom);
                @(posedge clk); #1;
                check({name, "_stall_valid"}, 64'(out_valid), 64'(1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_in_ready"},  64'(in_ready),  64'(1));
        check({name, "_post_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_post_count"},     64'(out_count), 64'(0));
        grp_idx.delete();
        grp_tag.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_tag    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_mask",      64'(out_mask),  64'(0));
        check("rst_count",     64'(out_count), 64'(0));
        check("rst_tag",       64'(out_tag),   64'(0));
        check("rst_err",       64'(out_err),   64'(0));

        // Three lanes, tag 3.
        send_beat(0, 3, 1'b0);
        send_beat(5, 3, 1'b0);
        send_beat(31, 3, 1'b1);
        check("basic_mask_const", 64'(out_mask), 64'h8000_0021);
        expect_group("basic", 0);

        // Single-beat group held in EMIT for four cycles.
        send_beat(7, 2, 1'b1);
        expect_group("single_stall", 4);

        // Duplicate lane.
        send_beat(2, 5, 1'b0);
        send_beat(2, 5, 1'b0);
        send_beat(9, 5, 1'b1);
        check("dup_mask_const", 64'(out_mask), 64'h0000_0204);
        expect_group("dup", 1);

        // Tag mismatch on the last beat.
        send_beat(10, 1, 1'b0);
        send_beat(11, 1, 1'b0);
        send_beat(12, 2, 1'b1);
        expect_group("tagmis", 0);

        // All lanes, descending.
        for (int i = LANES - 1; i >= 0; i--) send_beat(i, 6, i == 0);
        check("all_mask_const", 64'(out_mask), 64'hFFFF_FFFF);
        expect_group("all_lanes", 2);

        // Reset mid-group discards the partial group.
        send_beat(1, 7, 1'b0);
        send_beat(3, 7, 1'b0);
        send_beat(20, 7, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        grp_idx.delete();
        grp_tag.delete();
        check("midrst_in_ready", 64'(in_ready),  64'(1));
        check("midrst_mask",     64'(out_mask),  64'(0));
        check("midrst_count",    64'(out_count), 64'(0));
        send_beat(4, 8, 1'b1);
        check("after_rst_mask_const", 64'(out_mask), 64'h10);
        expect_group("after_rst", 0);

        // Overlong group of random lanes exercises count saturation.
        for (int i = 0; i < 40; i++) send_beat($urandom_range(LANES - 1), 9, i == 39);
        expect_group("long", 1);

        // Random groups.
        for (int g = 0; g < 60; g++) begin
            int len  = $urandom_range(1, 10);
            int base = $urandom_range(15);
            for (int b = 0; b < len; b++) begin
                int tg = ($urandom_range(9) == 0) ? $urandom_range(15) : base;
                send_beat($urandom_range(LANES - 1), tg, b == len - 1);
            end
            expect_group("rand", $urandom_range(3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
